// File: rtl/stdout_char_fifo_pkg.sv
// Shared types for the cluster stdout character FIFO.
package stdout_char_fifo_pkg;

    localparam int unsigned NUM_CORES = 8;
    localparam int unsigned CORE_IDX_W = $clog2(NUM_CORES);
    localparam logic [31:0] STDOUT_BASE = 32'h1A10_4000;
    localparam logic [11:0] STATUS_OFFS = 12'h800;

    typedef struct packed {
        logic                  eol;
        logic [5:0]            cluster_id;
        logic [CORE_IDX_W-1:0] core_id;
        logic [7:0]            ch;
    } stdout_entry_t;

    typedef enum logic [1:0] {
        REQ_CHAR,
        REQ_STAT,
        REQ_ERR
    } req_class_e;

    function automatic stdout_entry_t make_entry(
        input logic [5:0]            cid,
        input logic [CORE_IDX_W-1:0] core,
        input logic [7:0]            c
    );
        stdout_entry_t e;
        e.eol        = (c == 8'h0A);
        e.cluster_id = cid;
        e.core_id    = core;
        e.ch         = c;
        return e;
    endfunction

endpackage

// File: rtl/stdout_char_fifo_buf.sv
// Registered-write character FIFO; head is read straight from storage.
module stdout_char_fifo_buf
    import stdout_char_fifo_pkg::*;
#(
    parameter int unsigned Depth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  stdout_entry_t          data_i,
    input  logic                   pop_i,
    output stdout_entry_t          data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(Depth):0] usage_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    stdout_entry_t    mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CntW'(Depth));
    assign usage_o = count;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AddrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AddrW'(1);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/stdout_char_fifo.sv
// Cluster stdout device: decodes core byte writes, tags them and
// streams them out of a FIFO towards the host log writer.
module stdout_char_fifo
    import stdout_char_fifo_pkg::*;
#(
    parameter int unsigned NumCores   = NUM_CORES,
    parameter int unsigned FifoDepth  = 32,
    parameter logic [11:0] StatusOffs = STATUS_OFFS
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [5:0]                        cluster_id_i,
    input  logic                              req_i,
    input  logic [31:0]                       add_i,
    input  logic                              wen_i,
    input  logic [31:0]                       wdata_i,
    input  logic [3:0]                        be_i,
    input  logic [5:0]                        atop_i,
    output logic                              gnt_o,
    output logic                              r_valid_o,
    output logic [31:0]                       r_rdata_o,
    output logic                              r_opc_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [$bits(stdout_entry_t)-1:0]  out_data_o
);

    localparam int unsigned CoreIdxW = CORE_IDX_W;

    logic [11:0]          offs;
    logic [CoreIdxW-1:0]  core_idx;
    logic                 core_ok;
    logic                 is_char;
    logic                 is_stat;
    req_class_e           cls;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(FifoDepth):0] fill;
    stdout_entry_t        in_entry;
    stdout_entry_t        head;
    logic [31:0]          status;
    logic                 unused;

    assign offs     = add_i[11:0];
    assign core_idx = add_i[3 +: CoreIdxW];
    assign core_ok  = (32'(core_idx) < NumCores);

    assign is_char = ~wen_i & (atop_i == '0) & (offs < StatusOffs)
                   & be_i[0] & core_ok;
    assign is_stat = wen_i & (atop_i == '0) & (offs == StatusOffs);

    always_comb begin
        cls = REQ_ERR;
        unique case (1'b1)
            is_char: cls = REQ_CHAR;
            is_stat: cls = REQ_STAT;
            default: cls = REQ_ERR;
        endcase
    end

    // Full is registered, so the grant never depends on out_ready_i.
    assign gnt_o = rst_ni & req_i & ((cls != REQ_CHAR) | ~fifo_full);
    assign push  = gnt_o & (cls == REQ_CHAR);
    assign pop   = out_ready_i & ~fifo_empty;

    assign in_entry = make_entry(cluster_id_i, core_idx, wdata_i[7:0]);
    assign status   = {16'h0, 8'(fill), 7'h0, fifo_full};

    stdout_char_fifo_buf #(
        .Depth (FifoDepth)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (in_entry),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .usage_o (fill)
    );

    assign out_valid_o = ~fifo_empty;
    assign out_data_o  = head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_o <= 1'b0;
            r_rdata_o <= '0;
            r_opc_o   <= 1'b0;
        end else begin
            r_valid_o <= gnt_o;
            r_rdata_o <= (gnt_o && cls == REQ_STAT) ? status : '0;
            r_opc_o   <= gnt_o && (cls == REQ_ERR);
        end
    end

    assign unused = ^{add_i[31:12], add_i[2:0], wdata_i[31:8], be_i[3:1]};

endmodule

// File: tb/tb_stdout_char_fifo.sv
// Randomised scoreboard bench for stdout_char_fifo.
module tb_stdout_char_fifo;

    localparam int DEPTH = 32;
    localparam logic [31:0] BASE = 32'h1A10_4000;
    localparam int C_CHAR = 0;
    localparam int C_STAT = 1;
    localparam int C_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  cluster_id = 6'd3;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        wen = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hF;
    logic [5:0]  atop = '0;
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_data;

    always #5 clk = ~clk;

    stdout_char_fifo dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cluster_id_i (cluster_id),
        .req_i        (req),
        .add_i        (add),
        .wen_i        (wen),
        .wdata_i      (wdata),
        .be_i         (be),
        .atop_i       (atop),
        .gnt_o        (gnt),
        .r_valid_o    (r_valid),
        .r_rdata_o    (r_rdata),
        .r_opc_o      (r_opc),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
    } rsp_t;

    rsp_t        rspq[$];
    logic [17:0] strq[$];
    int          n_pass = 0;
    int          n_chk = 0;
    bit          done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int classify(input logic [31:0] a, input logic w,
                                    input logic [3:0] b, input logic [5:0] at);
        if (!w && at == 0 && a[11:0] < 12'h800 && b[0]) return C_CHAR;
        if (w && at == 0 && a[11:0] == 12'h800) return C_STAT;
        return C_ERR;
    endfunction

    // Scoreboard monitor: expectations from queues, sampled mid-cycle.
    int          m_fill;
    int          m_cls;
    logic        m_gnt;
    rsp_t        m_rsp;
    logic [7:0]  m_f8;
    logic [17:0] m_ent;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_r_valid", 32'(r_valid), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_gnt", 32'(gnt), 32'd0);
            rspq.delete();
            strq.delete();
        end else begin
            m_fill = strq.size();
            chk("r_valid", 32'(r_valid), 32'(rspq.size() != 0));
            if (r_valid && rspq.size() != 0) begin
                m_rsp = rspq.pop_front();
                chk("r_rdata", r_rdata, m_rsp.rdata);
                chk("r_opc", 32'(r_opc), 32'(m_rsp.opc));
            end
            chk("out_valid", 32'(out_valid), 32'(m_fill != 0));
            if (out_valid && m_fill != 0) begin
                chk("out_data", 32'(out_data), 32'(strq[0]));
                if (out_ready) void'(strq.pop_front());
            end
            m_cls = classify(add, wen, be, atop);
            m_gnt = req && (m_cls != C_CHAR || m_fill < DEPTH);
            chk("gnt", 32'(gnt), 32'(m_gnt));
            if (m_gnt) begin
                m_f8 = m_fill[7:0];
                m_rsp.rdata = (m_cls == C_STAT)
                    ? {16'h0, m_f8, 7'h0, m_fill == DEPTH} : 32'h0;
                m_rsp.opc = (m_cls == C_ERR);
                rspq.push_back(m_rsp);
                if (m_cls == C_CHAR) begin
                    m_ent = {wdata[7:0] == 8'h0A, cluster_id, add[5:3], wdata[7:0]};
                    strq.push_back(m_ent);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [5:0] at);
        int n = 0;
        @(posedge clk);
        #1;
        req = 1'b1; add = a; wen = w; wdata = d; be = b; atop = at;
        @(negedge clk);
        while (!gnt) begin
            n++;
            if (n > 500) begin
                n_chk++;
                $display("FAIL grant_timeout: addr %h never granted", a);
                req = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wr_char(input int core, input logic [7:0] c);
        do_req(BASE | 32'(core << 3), 1'b0, {24'h0, c}, 4'hF, 6'h0);
    endtask

    task automatic rd_stat();
        do_req(BASE + 32'h800, 1'b1, 32'h0, 4'hF, 6'h0);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req = 1'b0; wen = 1'b1; atop = '0; be = 4'hF;
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        while (out_valid || rspq.size() != 0) begin
            n++;
            if (n > 200) begin
                n_chk++;
                $display("FAIL drain_timeout: fill %0d left", strq.size());
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_ready(input int wait_cycles);
        repeat (wait_cycles) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Core 2 writes 'A' then newline.
        out_ready = 1'b1;
        wr_char(2, 8'h41);
        wr_char(2, 8'h0A);
        idle();
        repeat (3) @(negedge clk);

        // Fill completely with no consumer, then read status.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr_char(i % 8, 8'($urandom_range(32, 126)));
        rd_stat();
        idle();
        @(negedge clk);
        chk("stat_full", r_rdata, 32'h0000_2001);

        // Held write into a full FIFO, single-cycle pops let it through.
        for (int k = 0; k < 2; k++) begin
            fork
                wr_char(1, 8'h5A + 8'(k));
                pulse_ready(5);
            join
            idle();
        end
        drain();

        // Atomic write and read at a non-status offset.
        do_req(BASE + 32'h4, 1'b0, 32'h41, 4'hF, 6'h20);
        do_req(BASE + 32'h4, 1'b1, 32'h0, 4'hF, 6'h20);
        rd_stat();
        idle();
        @(negedge clk);
        chk("stat_after_atomic", r_rdata, 32'h0);

        // Back-to-back writes from cores 0, 5, 7.
        wr_char(0, 8'h30);
        wr_char(5, 8'h35);
        wr_char(7, 8'h37);
        idle();
        drain();

        // Reset with buffered entries and a response in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) wr_char(i % 8, 8'h61 + 8'(i));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_r_valid", 32'(r_valid), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_stat();
        idle();
        @(negedge clk);
        chk("stat_after_rst", r_rdata, 32'h0);

        // Randomised mix of traffic and consumer back-pressure.
        cluster_id = 6'h2A;
        fork
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int t = 0; t < 300; t++) begin
                    int kind;
                    int core;
                    logic [7:0] c;
                    kind = $urandom_range(0, 10);
                    core = $urandom_range(0, 7);
                    c = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
                    case (kind)
                        6: rd_stat();
                        7: do_req(BASE | 32'(core << 3), 1'b0, {24'h0, c},
                                  4'hF, 6'($urandom_range(1, 63)));
                        8: do_req(BASE | 32'(core << 3), 1'b0, {24'h0, c},
                                  4'hE, 6'h0);
                        9: do_req(BASE + 32'($urandom_range(0, 12'h7FF)),
                                  1'b1, 32'h0, 4'hF, 6'h0);
                        10: do_req(BASE + 32'($urandom_range(12'h800, 12'hFFF)),
                                   1'b0, {24'h0, c}, 4'hF, 6'h0);
                        default: wr_char(core, c);
                    endcase
                    if ($urandom_range(0, 3) == 0) idle();
                end
                idle();
                done = 1'b1;
            end
        join
        drain();
        chk("final_stream_empty", 32'(strq.size()), 32'd0);
        chk("final_rsp_empty", 32'(rspq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
